// File: rtl/cnt_pkg.sv
// Shared types and helpers for the shared-counter scheduler.
// Holds the FSM encoding and the index-to-one-hot helper.
package cnt_pkg;

  localparam int CW_DEF = 26;
  localparam int MAXREQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [MAXREQ-1:0] onehot(
    input logic [2:0] idx
  );
    logic [MAXREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or above ptr,
// wrapping past the top index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [IW-1:0]   win_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    win_o   = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % NREQ);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = idx;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one up-counter among NREQ requesters, timing one
// interval at a time and pulsing done to the owner.
module counter_sched
  import cnt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEF,
  parameter int IW   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] dur,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic [IW-1:0]      owner
);

  state_t            state_q, state_d;
  logic [CW-1:0]     target_q, target_d;
  logic [CW-1:0]     count_q, count_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;

  logic              pick_v;
  logic [IW-1:0]     pick_w;
  logic [CW-1:0]     dsel;
  logic [MAXREQ-1:0] oh_win;
  logic [MAXREQ-1:0] oh_own;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_v),
    .win_o   (pick_w)
  );

  assign dsel   = dur[int'(pick_w)*CW +: CW];
  assign oh_win = onehot(3'(pick_w));
  assign oh_own = onehot(3'(owner_q));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    grant_d  = grant_q;
    done_d   = '0;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          target_d = (dsel == '0) ? CW'(1) : dsel;
          count_d  = '0;
          grant_d  = oh_win[NREQ-1:0];
          owner_d  = pick_w;
          ptr_d    = (int'(pick_w) == NREQ - 1) ? '0
                                                : pick_w + 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // A dropped request aborts even on the final cycle.
        if (!req[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (count_q == target_q - 1'b1) begin
          grant_d = '0;
          done_d  = oh_own[NREQ-1:0];
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      target_q <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched against an interval-level
// reference model of the scheduler.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int IW   = 2;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] dur;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      count;
  logic [IW-1:0]      owner;

  counter_sched #(
    .NREQ (NREQ),
    .CW   (CW),
    .IW   (IW)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .req   (req),
    .dur   (dur),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count),
    .owner (owner)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 interval running, 2 done cycle.
  int ph, own, ptr, rem, tgt, cnt;
  int peak;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    ph  = 0;
    own = 0;
    ptr = 0;
    rem = 0;
    tgt = 0;
    cnt = 0;
  endtask

  task automatic m_edge();
    bit found;
    int i;
    int d;
    found = 1'b0;
    case (ph)
      0: begin
        for (int k = 0; k < NREQ; k++) begin
          i = (ptr + k) % NREQ;
          if (!found && req[i]) begin
            found = 1'b1;
            d   = int'(dur[i*CW +: CW]);
            tgt = (d == 0) ? 1 : d;
            rem = tgt;
            cnt = 0;
            own = i;
            ptr = (i + 1) % NREQ;
            ph  = 1;
          end
        end
      end
      1: begin
        if (!req[own]) begin
          ph = 0;
        end else begin
          rem--;
          if (rem == 0) ph = 2;
          else cnt = tgt - rem;
        end
      end
      default: ph = 0;
    endcase
  endtask

  task automatic check_all();
    logic [31:0] eg, ed;
    eg = (ph == 1) ? (32'd1 << own) : 32'd0;
    ed = (ph == 2) ? (32'd1 << own) : 32'd0;
    chk("grant", 32'(grant), eg);
    chk("done", 32'(done), ed);
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("count", 32'(count), 32'(cnt));
    chk("owner", 32'(owner), 32'(own));
    if (int'(count) > peak) peak = int'(count);
  endtask

  task automatic tick();
    m_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic set_dur(input int i, input int v);
    dur[i*CW +: CW] = CW'(v);
  endtask

  // Run until the model reaches its done cycle, bounded.
  task automatic run_to_done(input string tag, input int lim);
    int n;
    n = 0;
    while (ph != 2 && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_reached_done"}, 32'(ph == 2), 32'd1);
  endtask

  initial begin
    RST  = 1'b1;
    req  = '0;
    dur  = '0;
    peak = 0;
    m_reset();
    #2;
    check_all();
    #10;
    RST = 1'b0;

    // Single requester, five-cycle interval.
    req = 4'b0010;
    set_dur(1, 5);
    run_to_done("single", 20);
    req = '0;
    repeat (3) tick();

    // Continuous contention, all intervals three cycles.
    for (int i = 0; i < NREQ; i++) set_dur(i, 3);
    req = 4'b1111;
    repeat (26) tick();
    req = '0;
    repeat (6) tick();

    // Zero duration behaves as one cycle.
    req = 4'b0100;
    set_dur(2, 0);
    run_to_done("zero", 10);
    req = '0;
    repeat (3) tick();

    // Abort at count 7 while requester 3 waits.
    set_dur(0, 20);
    set_dur(3, 2);
    req = 4'b0001;
    while (ph != 1) tick();
    req = 4'b1001;
    for (int n = 0; n < 40 && !(ph == 1 && own == 0 && cnt == 7); n++)
      tick();
    chk("abort_at7", 32'(count), 32'd7);
    req = 4'b1000;
    repeat (2) tick();
    chk("abort_next_owner", 32'(grant), 32'b1000);
    run_to_done("after_abort", 10);
    req = '0;
    repeat (3) tick();

    // Longest interval for CW=8.
    set_dur(0, 255);
    req  = 4'b0001;
    peak = 0;
    run_to_done("max", 300);
    chk("max_peak", 32'(peak), 32'd254);
    req = '0;
    repeat (3) tick();

    // Asynchronous reset in the middle of an interval.
    set_dur(0, 10);
    req = 4'b0001;
    repeat (4) tick();
    #2;
    RST = 1'b1;
    #1;
    m_reset();
    check_all();
    #1;
    RST = 1'b0;
    repeat (3) tick();
    chk("post_reset_grant", 32'(grant), 32'b0001);
    req = '0;
    repeat (4) tick();

    // Random traffic with sticky request levels.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 7) == 0) set_dur(i, $urandom_range(0, 6));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
